// File: rtl/obstacle_scroller.sv
// -----------------------------------------------------------------------------
// obstacle_scroller
// Scrolling pipe field for a flappy-bird style game. Pipes are generated in
// column 0 every SPACING ticks with a random opening taken from a Fibonacci
// LFSR, shift one column towards COLS-1 per accepted tick, and are counted as
// they pass the bird column.
//
// Optional feature macro: OBSTACLE_SHRINK_EN
//   When defined, the pipe opening narrows by one row for every eight pipes
//   passed, never below one row.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        IDLE->RUN or FROZEN->IDLE command (level sampled)
//   i_tick         one-cycle scroll enable
//   i_halt         loss indication, freezes the field
//   i_seed_load    load LFSR from i_seed (zero seed loads 1)
//   i_seed         LFSR seed value
//   o_grid         pixel field, bit [c*ROWS+r] = column c, row r
//   o_score_pulse  one-cycle pulse when a pipe leaves BIRD_COL
//   o_pipe_count   pipes passed, saturating at 255
//   o_running      high while in RUN
// -----------------------------------------------------------------------------
module obstacle_scroller #(
    parameter int unsigned ROWS     = 8,
    parameter int unsigned COLS     = 8,
    parameter int unsigned GAP      = 3,
    parameter int unsigned SPACING  = 4,
    parameter int unsigned BIRD_COL = 6,
    parameter int unsigned LFSR_W   = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_tick,
    input  logic                   i_halt,
    input  logic                   i_seed_load,
    input  logic [LFSR_W-1:0]      i_seed,
    output logic [ROWS*COLS-1:0]   o_grid,
    output logic                   o_score_pulse,
    output logic [7:0]             o_pipe_count,
    output logic                   o_running
);

    localparam int unsigned GRID_W = ROWS * COLS;
    localparam int unsigned SP_W   = (SPACING > 2) ? $clog2(SPACING) : 1;

    // Maximal-length tap masks (bit n-1 set for tap n); widths outside the
    // table fall back to taps {W, W-1}, which is not guaranteed maximal.
    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        logic [31:0] taps;
        case (w)
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0003 << (w - 2);
        endcase
        return taps;
    endfunction

    localparam logic [31:0] TAPS_ALL = lfsr_taps(LFSR_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FROZEN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_accept;
    logic                   w_clear;

    logic                   r_running;
    logic [GRID_W-1:0]      r_grid;
    logic [SP_W-1:0]        r_sp_cnt;
    logic [7:0]             r_pipe_count;
    logic                   r_score;
    logic [LFSR_W-1:0]      r_lfsr;

    logic                   w_fb;
    logic [ROWS-1:0]        w_bird_col;
    logic [ROWS-1:0]        w_pipe_col;
    logic [ROWS-1:0]        w_new_col;
    int unsigned            w_gap;
    int unsigned            w_mod;
    int unsigned            w_offset;

    // State register; running mirrors the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_running <= (w_state_next == S_RUN);
        end
    end

    // Next state; halt wins over tick, and ticks only count while running.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_clear      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (i_halt)      w_state_next = S_FROZEN;
                else if (i_tick) w_accept     = 1'b1;
            end
            S_FROZEN: begin
                if (i_start) begin
                    w_state_next = S_IDLE;
                    w_clear      = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Effective opening height.
    always_comb begin
`ifdef OBSTACLE_SHRINK_EN
        int unsigned shrink;
        shrink = 32'(r_pipe_count[7:3]);
        w_gap  = (GAP > shrink) ? (GAP - shrink) : 32'd1;
`else
        w_gap  = GAP;
`endif
    end

    // New entry column: pipe with a clear band at lfsr mod (ROWS-G+1).
    always_comb begin
        w_mod    = ROWS - w_gap + 1;
        w_offset = 32'(r_lfsr) % w_mod;
        for (int unsigned r = 0; r < ROWS; r++) begin
            w_pipe_col[r] = !((r >= w_offset) && (r < w_offset + w_gap));
        end
        w_new_col = (r_sp_cnt == '0) ? w_pipe_col : '0;
    end

    assign w_fb       = ^(r_lfsr & TAPS_ALL[LFSR_W-1:0]);
    assign w_bird_col = r_grid[BIRD_COL*ROWS +: ROWS];

    // Field, spacing counter and scoring.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grid       <= '0;
            r_sp_cnt     <= '0;
            r_pipe_count <= '0;
            r_score      <= 1'b0;
        end else begin
            r_score <= 1'b0;
            if (w_clear) begin
                r_grid       <= '0;
                r_sp_cnt     <= '0;
                r_pipe_count <= '0;
            end else if (w_accept) begin
                r_grid   <= {r_grid[GRID_W-ROWS-1:0], w_new_col};
                r_sp_cnt <= (r_sp_cnt == SP_W'(SPACING - 1)) ? '0 : r_sp_cnt + 1'b1;
                if (|w_bird_col) begin
                    r_score <= 1'b1;
                    if (r_pipe_count != 8'hFF) r_pipe_count <= r_pipe_count + 8'd1;
                end
            end
        end
    end

    // Random source; an explicit seed load overrides the tick advance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= LFSR_W'(1);
        end else if (i_seed_load) begin
            r_lfsr <= (i_seed == '0) ? LFSR_W'(1) : i_seed;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
        end
    end

    assign o_grid        = r_grid;
    assign o_score_pulse = r_score;
    assign o_pipe_count  = r_pipe_count;
    assign o_running     = r_running;

endmodule

// File: tb/tb_obstacle_scroller.sv
// -----------------------------------------------------------------------------
// tb_obstacle_scroller
// Directed bench for obstacle_scroller at default parameters. Expected pipe
// columns are hand-derived from the 8-bit LFSR sequence 01,02,04,08,11,23,47,
// 8E,1C (taps 8,6,5,4) with opening rows lfsr mod 6 .. +2.
// -----------------------------------------------------------------------------
module tb_obstacle_scroller;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        tick;
    logic        halt;
    logic        seed_load;
    logic [7:0]  seed;
    logic [63:0] grid;
    logic        score_pulse;
    logic [7:0]  pipe_count;
    logic        running;

    int n_pass  = 0;
    int n_total = 0;

    obstacle_scroller dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_tick       (tick),
        .i_halt       (halt),
        .i_seed_load  (seed_load),
        .i_seed       (seed),
        .o_grid       (grid),
        .o_score_pulse(score_pulse),
        .o_pipe_count (pipe_count),
        .o_running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] col(input int c);
        return grid[c*8 +: 8];
    endfunction

    // One clock with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic s, input logic t, input logic h,
                       input logic sl, input logic [7:0] sd);
        start = s; tick = t; halt = h; seed_load = sl; seed = sd;
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; halt = 1'b0; seed_load = 1'b0; seed = 8'h00;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; tick = 1'b0; halt = 1'b0; seed_load = 1'b0; seed = 8'h00;
        #3;
        n_total++; if (grid !== 64'd0) $display("FAIL reset_grid got=%h exp=0", grid); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL reset_running got=%b exp=0", running); else n_pass++;
        n_total++; if (score_pulse !== 1'b0) $display("FAIL reset_score got=%b exp=0", score_pulse); else n_pass++;
        n_total++; if (pipe_count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", pipe_count); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_idle_ticks();
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (grid !== 64'd0) $display("FAIL idle_tick_grid got=%h exp=0", grid); else n_pass++;
        cyc(0, 0, 0, 1, 8'h01);
        cyc(1, 1, 0, 0, 8'h00);
        n_total++; if (running !== 1'b1) $display("FAIL start_running got=%b exp=1", running); else n_pass++;
        n_total++; if (grid !== 64'd0) $display("FAIL start_tick_grid got=%h exp=0", grid); else n_pass++;
    endtask

    task automatic test_first_pipe();
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (col(0) !== 8'hF1) $display("FAIL first_pipe got=%h exp=f1", col(0)); else n_pass++;
        n_total++; if (running !== 1'b1) $display("FAIL first_running got=%b exp=1", running); else n_pass++;
    endtask

    task automatic test_spacing();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (col(3) !== 8'hF1) $display("FAIL sp_col3 got=%h exp=f1", col(3)); else n_pass++;
        n_total++; if (col(2) !== 8'h00) $display("FAIL sp_col2 got=%h exp=00", col(2)); else n_pass++;
        n_total++; if (col(1) !== 8'h00) $display("FAIL sp_col1 got=%h exp=00", col(1)); else n_pass++;
        n_total++; if (col(0) !== 8'h00) $display("FAIL sp_col0 got=%h exp=00", col(0)); else n_pass++;
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (col(0) !== 8'h1F) $display("FAIL second_pipe got=%h exp=1f", col(0)); else n_pass++;
        n_total++; if (col(4) !== 8'hF1) $display("FAIL sp_col4 got=%h exp=f1", col(4)); else n_pass++;
    endtask

    task automatic test_score();
        cyc(0, 1, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (score_pulse !== 1'b0) $display("FAIL score_early got=%b exp=0", score_pulse); else n_pass++;
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (score_pulse !== 1'b1) $display("FAIL score_pulse got=%b exp=1", score_pulse); else n_pass++;
        n_total++; if (pipe_count !== 8'd1) $display("FAIL score_count got=%0d exp=1", pipe_count); else n_pass++;
        n_total++; if (col(7) !== 8'hF1) $display("FAIL score_col7 got=%h exp=f1", col(7)); else n_pass++;
        cyc(0, 0, 0, 0, 8'h00);
        n_total++; if (score_pulse !== 1'b0) $display("FAIL score_width got=%b exp=0", score_pulse); else n_pass++;
        n_total++; if (pipe_count !== 8'd1) $display("FAIL count_hold got=%0d exp=1", pipe_count); else n_pass++;
    endtask

    task automatic test_halt_priority();
        logic [63:0] exp_grid;
        exp_grid = 64'hF100_0000_1F00_0000;
        n_total++; if (grid !== exp_grid) $display("FAIL pre_halt_grid got=%h exp=%h", grid, exp_grid); else n_pass++;
        cyc(0, 1, 1, 0, 8'h00);
        n_total++; if (grid !== exp_grid) $display("FAIL halt_grid got=%h exp=%h", grid, exp_grid); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL halt_running got=%b exp=0", running); else n_pass++;
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (grid !== exp_grid) $display("FAIL frozen_tick got=%h exp=%h", grid, exp_grid); else n_pass++;
        cyc(1, 0, 0, 0, 8'h00);
        n_total++; if (grid !== 64'd0) $display("FAIL unfreeze_grid got=%h exp=0", grid); else n_pass++;
        n_total++; if (pipe_count !== 8'd0) $display("FAIL unfreeze_count got=%0d exp=0", pipe_count); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL unfreeze_running got=%b exp=0", running); else n_pass++;
        // LFSR kept its 1C, sp_cnt restarted at 0 -> opening rows 4..6
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (col(0) !== 8'h8F) $display("FAIL retained_lfsr got=%h exp=8f", col(0)); else n_pass++;
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (grid !== 64'd0) $display("FAIL async_grid got=%h exp=0", grid); else n_pass++;
        n_total++; if (running !== 1'b0) $display("FAIL async_running got=%b exp=0", running); else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 1, 8'h55);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 8'h00);
        n_total++; if (col(0) !== 8'hF1) $display("FAIL seed_zero got=%h exp=f1", col(0)); else n_pass++;
    endtask

`ifdef OBSTACLE_SHRINK_EN
    task automatic test_shrink();
        int guard;
        int zeros;
        guard = 0;
        while (pipe_count != 8'd16 && guard < 200) begin
            cyc(0, 1, 0, 0, 8'h00);
            guard++;
        end
        n_total++; if (pipe_count !== 8'd16) $display("FAIL shrink_reach got=%0d exp=16", pipe_count); else n_pass++;
        // Step until the next pipe appears at the entry column
        guard = 0;
        do begin
            cyc(0, 1, 0, 0, 8'h00);
            guard++;
        end while (col(0) == 8'h00 && guard < 8);
        zeros = 0;
        for (int r = 0; r < 8; r++) if (col(0)[r] == 1'b0) zeros++;
        n_total++; if (zeros !== 1) $display("FAIL shrink_gap got=%0d exp=1", zeros); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_idle_ticks();
        test_first_pipe();
        test_spacing();
        test_score();
        test_halt_priority();
        test_async_reset();
`ifdef OBSTACLE_SHRINK_EN
        test_shrink();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
